// File: rtl/alu_seq.sv
// Sequential zx/nx/zy/ny/f/no ALU with a registered result and status flags.
// Multiply and shift modes iterate one step per cycle behind a valid/ready handshake.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, hi_q, hi_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             no_q, no_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d, ng_q, ng_d, cy_q, cy_d;

    logic [WIDTH-1:0] xp, yp, src_x, src_y, src_hi, st_x, st_y, st_hi, r, res;
    logic [WIDTH:0]   asum, msum;
    logic [SHW-1:0]   amt;
    logic [1:0]       s_mode;
    logic             s_no, idle, finish, st_c, rcy;

    always_comb begin
        xp     = zx ? '0 : in0;
        xp     = nx ? ~xp : xp;
        yp     = zy ? '0 : in1;
        yp     = ny ? ~yp : yp;
        amt    = yp[SHW-1:0];
        asum   = {1'b0, xp} + {1'b0, yp};
        idle   = (state_q == S_IDLE);

        // The accept edge performs the first iteration step straight from the
        // conditioned operands, so L edges cover exactly L steps.
        src_x  = idle ? xp : x_q;
        src_y  = idle ? yp : y_q;
        src_hi = idle ? '0 : hi_q;
        s_mode = idle ? mode : mode_q;
        s_no   = idle ? no : no_q;

        msum  = {1'b0, src_hi} + (src_y[0] ? {1'b0, src_x} : '0);
        st_x  = src_x;
        st_y  = src_y;
        st_hi = src_hi;
        st_c  = 1'b0;
        case (s_mode)
            2'd1: begin
                st_hi = msum[WIDTH:1];
                st_y  = {msum[0], src_y[WIDTH-1:1]};
            end
            2'd2: begin
                st_x = {src_x[WIDTH-2:0], 1'b0};
                st_c = src_x[WIDTH-1];
            end
            2'd3: begin
                st_x = {src_x[WIDTH-1], src_x[WIDTH-1:1]};
                st_c = src_x[0];
            end
            default: ;
        endcase

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        no_d    = no_q;
        out_d   = out_q;
        zr_d    = zr_q;
        ng_d    = ng_q;
        cy_d    = cy_q;
        finish  = 1'b0;
        r       = '0;
        rcy     = 1'b0;
        res     = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d = mode;
                    no_d   = no;
                    x_d    = st_x;
                    y_d    = st_y;
                    hi_d   = st_hi;
                    case (mode)
                        2'd0: begin
                            finish = 1'b1;
                            r      = f ? asum[WIDTH-1:0] : (xp & yp);
                            rcy    = f & asum[WIDTH];
                        end
                        2'd1: begin
                            cnt_d   = SHW'(WIDTH - 1);
                            state_d = S_BUSY;
                        end
                        default: begin
                            if (amt <= SHW'(1)) begin
                                finish = 1'b1;
                                r      = (amt == '0) ? xp : st_x;
                                rcy    = (amt == '0) ? 1'b0 : st_c;
                            end else begin
                                cnt_d   = amt - SHW'(1);
                                state_d = S_BUSY;
                            end
                        end
                    endcase
                end
            end
            S_BUSY: begin
                x_d   = st_x;
                y_d   = st_y;
                hi_d  = st_hi;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    finish = 1'b1;
                    r      = (mode_q == 2'd1) ? st_y : st_x;
                    rcy    = (mode_q == 2'd1) ? (|st_hi) : st_c;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            res     = s_no ? ~r : r;
            state_d = S_DONE;
            out_d   = res;
            zr_d    = (res == '0);
            ng_d    = res[WIDTH-1];
            cy_d    = rcy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            no_q    <= 1'b0;
            out_q   <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            no_q    <= no_d;
            out_q   <= out_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
            cy_q    <= cy_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign cy        = cy_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and randomized operations checked against an
// arithmetic reference model, plus backpressure and asynchronous reset scenarios.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in0 = '0, in1 = '0;
    logic         zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] out;
    logic         zr, ng, cy, out_valid;
    logic         out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .mode(mode), .out(out), .zr(zr), .ng(ng), .cy(cy),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // ctl packs {zx, nx, zy, ny, f, no}
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [5:0] ctl, input logic [1:0] m,
                                  output logic [W-1:0] eo, output logic ezr,
                                  output logic eng, output logic ecy, output int elat);
        logic [W-1:0]   xp, yp, r;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        int             amt;
        xp = ctl[5] ? '0 : a;
        if (ctl[4]) xp = ~xp;
        yp = ctl[3] ? '0 : b;
        if (ctl[2]) yp = ~yp;
        amt = int'(yp % W);
        ecy = 1'b0;
        case (m)
            2'd0: begin
                s = {1'b0, xp} + {1'b0, yp};
                r = ctl[1] ? s[W-1:0] : (xp & yp);
                ecy = ctl[1] ? s[W] : 1'b0;
                elat = 1;
            end
            2'd1: begin
                p = {{W{1'b0}}, xp} * {{W{1'b0}}, yp};
                r = p[W-1:0];
                ecy = (p[2*W-1:W] != 0);
                elat = W;
            end
            2'd2: begin
                r = xp << amt;
                if (amt > 0) ecy = xp[W-amt];
                elat = (amt == 0) ? 1 : amt;
            end
            default: begin
                r = $signed(xp) >>> amt;
                if (amt > 0) ecy = xp[amt-1];
                elat = (amt == 0) ? 1 : amt;
            end
        endcase
        eo  = ctl[0] ? ~r : r;
        ezr = (eo == 0);
        eng = eo[W-1];
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [5:0] ctl, input logic [1:0] m,
                          output logic [W-1:0] o, output logic ozr, output logic ong,
                          output logic ocy, output int lat);
        in0 = a; in1 = b; {zx, nx, zy, ny, f, no} = ctl; mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in0 = W'($urandom); in1 = W'($urandom);
        {zx, nx, zy, ny, f, no} = 6'($urandom); mode = 2'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        o = out; ozr = zr; ong = ng; ocy = cy;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if ({out, zr, ng, cy, out_valid, in_ready} !== {{W{1'b0}}, 5'b00001}) begin
            bad++;
            $display("FAIL reset_state got out=%h zr=%b ng=%b cy=%b ov=%b ir=%b exp out=0 flags=0 ov=0 ir=1",
                     out, zr, ng, cy, out_valid, in_ready);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] a[9], b[9], eo[9], o;
        logic [5:0]   c[9];
        logic [1:0]   m[9];
        logic [2:0]   ef[9];
        int           el[9];
        logic         ozr, ong, ocy;
        int           lat;
        a = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd300, 16'hFFFF, 16'h0001, 16'h8000, 16'h1234};
        b = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd300, 16'h0001, 16'd15,   16'd4,    16'd0};
        c = '{6'b000010, 6'b010011, 6'b111100, 6'b101010, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
        m = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        eo = '{16'h0008, 16'h0002, 16'hFFFF, 16'h0000, 16'h5F90, 16'hFFFF, 16'h8000, 16'hF800, 16'h1234};
        ef = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b010, 3'b010, 3'b010, 3'b000};
        el = '{1, 1, 1, 1, 16, 16, 15, 4, 1};
        for (int i = 0; i < 9; i++) begin
            run_op(a[i], b[i], c[i], m[i], o, ozr, ong, ocy, lat);
            total++;
            if ({o, ozr, ong, ocy} !== {eo[i], ef[i]} || lat != el[i]) begin
                bad++;
                $display("FAIL directed_%0d got out=%h zr/ng/cy=%b%b%b lat=%0d exp out=%h zr/ng/cy=%b lat=%0d",
                         i, o, ozr, ong, ocy, lat, eo[i], ef[i], el[i]);
            end
            release_out();
        end
        // single-step shift goes straight to DONE and still reports the bit shifted out
        run_op(16'h8001, 16'd1, 6'b0, 2'd2, o, ozr, ong, ocy, lat);
        total++;
        if ({o, ocy} !== {16'h0002, 1'b1} || lat != 1) begin
            bad++;
            $display("FAIL shl_by_one got out=%h cy=%b lat=%0d exp out=0002 cy=1 lat=1", o, ocy, lat);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, o, eo;
        logic [5:0]   c;
        logic [1:0]   m;
        logic         ozr, ong, ocy, ezr, eng, ecy;
        int           lat, elat;
        for (int i = 0; i < 80; i++) begin
            a = W'($urandom); b = W'($urandom); c = 6'($urandom); m = 2'($urandom);
            model(a, b, c, m, eo, ezr, eng, ecy, elat);
            run_op(a, b, c, m, o, ozr, ong, ocy, lat);
            total++;
            if ({o, ozr, ong, ocy} !== {eo, ezr, eng, ecy} || lat != elat) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h ctl=%b m=%0d got out=%h f=%b%b%b lat=%0d exp out=%h f=%b%b%b lat=%0d",
                         i, a, b, c, m, o, ozr, ong, ocy, lat, eo, ezr, eng, ecy, elat);
            end
            release_out();
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== eo || cy !== ecy) begin
                bad++;
                $display("FAIL random_release_%0d got ir=%b ov=%b out=%h cy=%b exp ir=1 ov=0 out=%h cy=%b",
                         i, in_ready, out_valid, out, cy, eo, ecy);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] o, eo;
        logic         ozr, ong, ocy, ezr, eng, ecy;
        int           lat, elat;
        model(16'h1234, 16'h0ABC, 6'b0, 2'd1, eo, ezr, eng, ecy, elat);
        run_op(16'h1234, 16'h0ABC, 6'b0, 2'd1, o, ozr, ong, ocy, lat);
        total++;
        if ({o, ozr, ong, ocy} !== {eo, ezr, eng, ecy}) begin
            bad++;
            $display("FAIL bp_result got out=%h exp out=%h", o, eo);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'(i % 2 == 0); in0 = W'($urandom); in1 = W'($urandom); mode = 2'($urandom);
            @(posedge clk); #1;
            total++;
            if ({out, zr, ng, cy, out_valid, in_ready} !== {eo, ezr, eng, ecy, 2'b10}) begin
                bad++;
                $display("FAIL bp_hold_%0d got out=%h ov=%b ir=%b exp out=%h ov=1 ir=0", i, out, out_valid, in_ready, eo);
            end
        end
        in_valid = 1'b0;
        release_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== eo) begin
            bad++;
            $display("FAIL bp_release got ir=%b ov=%b out=%h exp ir=1 ov=0 out=%h", in_ready, out_valid, out, eo);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] o;
        logic         ozr, ong, ocy;
        int           lat;
        run_op(16'd5, 16'd3, 6'b000010, 2'd0, o, ozr, ong, ocy, lat);
        release_out();
        in0 = 16'd300; in1 = 16'd300; {zx, nx, zy, ny, f, no} = 6'b0; mode = 2'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({out, zr, ng, cy, out_valid, in_ready} !== {{W{1'b0}}, 5'b00001}) begin
            bad++;
            $display("FAIL midop_reset got out=%h zr=%b ng=%b cy=%b ov=%b ir=%b exp out=0 flags=0 ov=0 ir=1",
                     out, zr, ng, cy, out_valid, in_ready);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_op(16'd5, 16'd3, 6'b000010, 2'd0, o, ozr, ong, ocy, lat);
        total++;
        if ({o, ozr, ong, ocy} !== {16'h0008, 3'b000} || lat != 1) begin
            bad++;
            $display("FAIL post_reset_add got out=%h f=%b%b%b lat=%0d exp out=0008 f=000 lat=1", o, ozr, ong, ocy, lat);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-mode sequential ALU. It is the next generation of the 16-bit combinational zx/nx/zy/ny/f/no ALU.
- Keeps that ALU's operand-conditioning and function controls.
- Adds registered results, status flags, and multi-cycle multiply and barrel-free shift modes.
- Uses a valid/ready handshake on both sides.
- Sits between the register file/operand muxes and the writeback stage of the CPU datapath.

Parameters:
WIDTH, 16, datapath width in bits; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
in0  input  WIDTH  operand x
in1  input  WIDTH  operand y
zx  input  1  zero x
nx  input  1  invert x (applied after zx)
zy  input  1  zero y
ny  input  1  invert y (applied after zy)
f  input  1  mode 0 only: 1 = add, 0 = and
no  input  1  invert final result (all modes)
mode  input  2  0 = logic/add, 1 = multiply, 2 = shift left logical, 3 = shift right arithmetic
out  output  WIDTH  result
zr  output  1  out == 0
ng  output  1  out[WIDTH-1]
cy  output  1  carry/overflow/shifted-out bit
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result

Behaviour:
- Reset is asynchronous and active-high on rst, and may occur at any time including mid-operation. It gives:
  - state = IDLE
  - out = 0, zr = 0, ng = 0, cy = 0, out_valid = 0
  - in_ready = 1 once in IDLE
  - any operation in progress is discarded.
- Operand conditioning is evaluated once, at the accept edge:
  - xp = nx ? ~(zx ? 0 : in0) : (zx ? 0 : in0)
  - yp is formed the same way from in1, zy, ny.
- Accept rule:
  - A request is accepted on a rising edge with in_valid && in_ready.
  - xp, yp, mode, f and no are captured at that edge. Later input changes are ignored.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - BUSY: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Transitions:
  - IDLE -> BUSY on accept, with the cycle counter loaded with L-1.
  - If L = 1, IDLE -> DONE directly at the accept edge.
  - BUSY -> DONE when the counter reaches 0.
  - DONE -> IDLE on out_valid && out_ready.
  - No new accept occurs in the same cycle as a DONE handshake.
- Latency L is counted as edges, from the accept edge inclusive to the first cycle with out_valid = 1:
  - mode 0: L = 1
  - mode 1: L = WIDTH
  - modes 2/3: L = max(amt, 1), where amt = yp[SHW-1:0] (unsigned).
- Mode 0:
  - r = f ? (xp + yp) mod 2^WIDTH : xp & yp.
  - cy = carry-out of the add when f = 1, else 0.
- Mode 1:
  - Shift-add multiplier, one multiplier bit per cycle, unsigned.
  - r = low WIDTH bits of xp*yp.
  - cy = 1 iff any bit of the upper WIDTH product bits is nonzero.
- Mode 2:
  - One position per cycle; r = xp << amt.
  - cy = last bit shifted out; 0 if amt = 0.
- Mode 3:
  - One position per cycle with sign fill; r = xp >>> amt.
  - cy = last bit shifted out; 0 if amt = 0.
- Output formation, all modes:
  - out = no ? ~r : r, registered on entry to DONE.
  - zr and ng are computed from the final out.
  - cy is not affected by no.
- Output hold:
  - out, zr, ng and cy stay stable while out_valid = 1 && out_ready = 0.
  - They hold their last value after returning to IDLE until the next entry to DONE.
- Constraints:
  - in_valid, in0, in1 and the control inputs are don't-care when in_ready = 0.
  - amt >= WIDTH cannot occur, because amt is SHW bits wide.

Test Plan:
1. WIDTH=16, mode 0, in0=5, in1=3, f=1, all other controls 0 -> out=0x0008, zr=0, ng=0, cy=0; out_valid on the cycle after accept.
2. Mode 0, in0=5, in1=3, nx=1, f=1, no=1 (x-y); then zx=1, nx=1, zy=1, f=0 (x=-1 & ~0) -> first out=0x0002, second out=0xFFFF with ng=1; then zx=zy=1, f=1 -> out=0, zr=1.
3. Mode 1, in0=300, in1=300 -> out=0x5F90, cy=1; out_valid exactly 16 edges after the accept edge. Then in0=0xFFFF, in1=1 -> out=0xFFFF, cy=0.
4. Mode 2, in0=0x0001, in1=15 -> out=0x8000, ng=1, cy=0 after 15 edges. Mode 3, in0=0x8000, in1=4 -> out=0xF800, cy=0 after 4 edges. Mode 3, in1=0 -> out=in0 after 1 edge.
5. Backpressure: complete any op and hold out_ready=0 for 5 cycles -> out/flags stable, out_valid=1, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next edge, in_ready=1.
6. Assert rst asynchronously (between edges) 7 cycles into a mode 1 op -> out=0, flags=0, out_valid=0 immediately. After release in_ready=1; a fresh mode 0 op (5+3) returns 0x0008 with no residue.
